// File: rtl/controle_multiciclo_if.sv
// Instruction/data memory handshake between the main control FSM and the memory.
interface controle_multiciclo_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/controle_multiciclo.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable plus the AluOP consumed by the ULA control.
module controle_multiciclo #(
  parameter int           OP_W     = 6,
  parameter logic [3:0]   FUNCT_JR = 4'd9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [OP_W-1:0]   opcode,
  input  logic [3:0]        funct,
  controle_multiciclo_if.master mem,
  output logic [3:0]        AluOP,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        reg_dst,
  output logic [1:0]        pc_source,
  output logic              illegal,
  output logic              halted,
  output logic [3:0]        estado
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BGT  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SUBI = OP_W'(10);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(11);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(13);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_EXEC_I = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_MEM_WR = 4'd9,
    S_WB_MEM = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_JAL    = 4'd13,
    S_JR     = 4'd14,
    S_HALT   = 4'd15
  } state_t;

  state_t            state, state_nx;
  logic [OP_W-1:0]   op_q;
  logic              req, we;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_nx      = state;
    req           = 1'b0;
    we            = 1'b0;
    AluOP         = 4'b0000;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    reg_dst       = 2'd0;
    pc_source     = 2'd0;
    illegal       = 1'b0;
    halted        = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        req       = 1'b1;
        alu_src_b = 2'd1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        // branch target is precomputed here while the opcode is dispatched
        alu_src_b = 2'd3;
        case (opcode)
          OP_R:                         state_nx = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:                 state_nx = S_ADDR;
          OP_BEQ, OP_BLT, OP_BGT, OP_BNE:   state_nx = S_BRANCH;
          OP_ANDI, OP_ORI, OP_ADDI, OP_SUBI: state_nx = S_EXEC_I;
          OP_J:                         state_nx = S_JUMP;
          OP_JAL:                       state_nx = S_JAL;
          OP_HALT:                      state_nx = S_HALT;
          default: begin
            illegal  = 1'b1;
            state_nx = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        AluOP    = 4'b0001;
        state_nx = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
        state_nx  = S_FETCH;
      end
      S_EXEC_I: begin
        case (op_q)
          OP_ANDI: AluOP = 4'b0110;
          OP_ORI:  AluOP = 4'b0111;
          OP_ADDI: AluOP = 4'b1000;
          default: AluOP = 4'b1001;
        endcase
        alu_src_b = 2'd2;
        state_nx  = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        state_nx  = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nx  = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        req = 1'b1;
        if (mem.mem_ready) state_nx = S_WB_MEM;
      end
      S_MEM_WR: begin
        req = 1'b1;
        we  = 1'b1;
        if (mem.mem_ready) state_nx = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BRANCH: begin
        case (op_q)
          OP_BEQ:  AluOP = 4'b0010;
          OP_BLT:  AluOP = 4'b0011;
          OP_BGT:  AluOP = 4'b0100;
          default: AluOP = 4'b0101;
        endcase
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        state_nx      = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        state_nx  = S_FETCH;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        reg_write = 1'b1;
        reg_dst   = 2'd2;
        state_nx  = S_FETCH;
      end
      S_JR: begin
        AluOP     = 4'b0001;
        pc_write  = 1'b1;
        pc_source = 2'd3;
        state_nx  = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

  assign mem.mem_req = req;
  assign mem.mem_we  = we;
  assign estado      = state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench: per-instruction expected output sequences built from the
// instruction semantics, replayed cycle by cycle against the control FSM.
module tb_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [3:0] funct = '0;
  logic [3:0] AluOP;
  logic       ir_write, pc_write, pc_write_cond, reg_write, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, reg_dst, pc_source;
  logic       illegal, halted;
  logic [3:0] estado;

  controle_multiciclo_if bus();

  controle_multiciclo #(.OP_W(6), .FUNCT_JR(4'd9)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .mem(bus),
    .AluOP(AluOP), .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_dst(reg_dst), .pc_source(pc_source),
    .illegal(illegal), .halted(halted), .estado(estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] alu;
    logic req, we, irw, pcw, pcwc, rw, m2r, asa;
    logic [1:0] asb, rdst, pcs;
    logic ill, hlt;
  } out_t;

  int n_cmp = 0;
  int n_err = 0;

  out_t exp_q[$];
  int   rdy_q[$];   // 0/1 forced mem_ready, 2 = random (ignored by the FSM)
  bit   dec_q[$];   // cycle where the real opcode must be presented

  function automatic out_t observe();
    out_t o;
    o = {AluOP, bus.mem_req, bus.mem_we, ir_write, pc_write, pc_write_cond, reg_write,
         mem_to_reg, alu_src_a, alu_src_b, reg_dst, pc_source, illegal, halted};
    return o;
  endfunction

  task automatic push(input out_t e, input int r, input bit d);
    exp_q.push_back(e);
    rdy_q.push_back(r);
    dec_q.push_back(d);
  endtask

  // expected cycle-by-cycle behaviour of one instruction, including memory waits
  task automatic build(input int op, input int fn, input int fw, input int mw);
    out_t e;
    for (int i = 0; i < fw; i++) begin
      e = '0; e.req = 1; e.asb = 2'd1; push(e, 0, 0);
    end
    e = '0; e.req = 1; e.asb = 2'd1; e.irw = 1; e.pcw = 1; push(e, 1, 0);
    e = '0; e.asb = 2'd3; e.ill = (op > 13); push(e, 2, 1);
    if (op == 0 && fn == 9) begin
      e = '0; e.alu = 4'd1; e.pcw = 1; e.pcs = 2'd3; push(e, 2, 0);
    end else if (op == 0) begin
      e = '0; e.alu = 4'd1; push(e, 2, 0);
      e = '0; e.rw = 1; e.rdst = 2'd1; push(e, 2, 0);
    end else if (op == 1 || op == 2) begin
      e = '0; e.asa = 1; e.asb = 2'd2; push(e, 2, 0);
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.req = 1; e.we = (op == 2); push(e, (i == mw) ? 1 : 0, 0);
      end
      if (op == 1) begin
        e = '0; e.rw = 1; e.m2r = 1; push(e, 2, 0);
      end
    end else if (op >= 3 && op <= 6) begin
      e = '0; e.alu = 4'(op - 1); e.asa = 1; e.pcwc = 1; e.pcs = 2'd1; push(e, 2, 0);
    end else if (op >= 7 && op <= 10) begin
      e = '0; e.alu = 4'(op - 1); e.asb = 2'd2; push(e, 2, 0);
      e = '0; e.rw = 1; push(e, 2, 0);
    end else if (op == 11) begin
      e = '0; e.pcw = 1; e.pcs = 2'd2; push(e, 2, 0);
    end else if (op == 12) begin
      e = '0; e.pcw = 1; e.pcs = 2'd2; e.rw = 1; e.rdst = 2'd2; push(e, 2, 0);
    end else if (op == 13) begin
      e = '0; e.hlt = 1; push(e, 2, 0);
    end
  endtask

  // entered and left at #1 after a rising edge; limit < 0 runs the whole queue
  task automatic run(input string tag, input int op, input int fn, input int limit);
    out_t e, o;
    int   r, k;
    k = 0;
    while (exp_q.size() > 0 && (limit < 0 || k < limit)) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      if (dec_q.pop_front()) begin
        opcode = 6'(op);
        funct  = 4'(fn);
      end else begin
        opcode = 6'($urandom);
        funct  = 4'($urandom);
      end
      bus.mem_ready = (r == 2) ? 1'($urandom) : 1'(r);
      @(negedge clock);
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, k, o, e);
      end
      @(posedge clock);
      #1;
      k++;
    end
    exp_q.delete();
    rdy_q.delete();
    dec_q.delete();
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (observe() !== '0 || estado !== 4'd0) begin
      n_err++;
      $display("FAIL %s async: got %h/%0d expected 0/0", tag, observe(), estado);
    end
    @(negedge clock);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (observe() !== '0 || estado !== 4'd0) begin
      n_err++;
      $display("FAIL %s idle: got %h/%0d expected 0/0", tag, observe(), estado);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b0;
    #3;
    do_reset("reset");
    build(7, 0, 1, 0);
    run("reset_fetch", 7, 0, -1);
  endtask

  task automatic test_r_type();
    build(0, 2, 0, 0);
    run("r_type", 0, 2, -1);
  endtask

  task automatic test_lw_wait();
    build(1, 0, 0, 3);
    run("lw_wait", 1, 0, -1);
    build(2, 0, 1, 2);
    run("sw_wait", 2, 0, -1);
  endtask

  task automatic test_branches();
    for (int op = 3; op <= 6; op++) begin
      build(op, 0, 0, 0);
      run("branch", op, 0, -1);
    end
  endtask

  task automatic test_itype_jumps();
    for (int op = 7; op <= 12; op++) begin
      build(op, 0, 0, 0);
      run("itype_jump", op, 0, -1);
    end
    build(0, 9, 0, 0);
    run("jr", 0, 9, -1);
  endtask

  task automatic test_illegal();
    build(15, 0, 0, 0);
    run("illegal", 15, 0, -1);
    build(63, 0, 2, 0);
    run("illegal63", 63, 0, -1);
  endtask

  task automatic test_reset_mid_memrd();
    build(1, 0, 0, 5);
    run("memrd_pre", 1, 0, 4);
    do_reset("memrd_reset");
    build(0, 2, 0, 0);
    run("memrd_after", 0, 2, -1);
  endtask

  task automatic test_back_to_back();
    int r, op, fn;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 15);
      fn = $urandom_range(0, 15);
      if (r <= 12) op = r;
      else if (r == 13) op = $urandom_range(14, 63);
      else op = 0;
      if (op == 0) fn = (r == 14) ? 9 : ((fn == 9) ? 2 : fn);
      build(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
      run("random", op, fn, -1);
    end
  endtask

  task automatic test_halt();
    out_t e;
    build(13, 0, 0, 0);
    e = '0; e.hlt = 1;
    for (int i = 0; i < 99; i++) push(e, 2, 0);
    run("halt", 13, 0, -1);
    do_reset("halt_reset");
    build(9, 0, 0, 0);
    run("halt_recover", 9, 0, -1);
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_branches();
    test_itype_jumps();
    test_illegal();
    test_reset_mid_memrd();
    test_back_to_back();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
